core_ctrl: RTL and testbench
============================

Name: core_ctrl

Overview:
- Instruction sequencer for one core tile. It drives the 50-bit inst bus of core for one complete layer pass: fetch weights from xmem into L0, load them into the PE array, fetch activations, execute, and drain OFIFO results into pmem.
- It sits between the host/testbench start interface and core, and replaces hand-written instruction streams.

Parameters:
row, 8, PE array rows (weight vectors fetched per pass)
col, 8, PE array columns (load propagation cycles)
XADDR_W, 11, xmem address width
PADDR_W, 14, pmem address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  begin a pass; sampled only in IDLE
mode  in  1  PE mode bit; latched at start, driven on inst[2] for the whole pass
w_base  in  XADDR_W  xmem address of weight vector 0
x_base  in  XADDR_W  xmem address of activation vector 0
x_len  in  XADDR_W  number of activation vectors (1..2^XADDR_W-1)
p_base  in  PADDR_W  pmem address of output 0
ofifo_valid  in  1  OFIFO holds a complete output row
inst  out  50  core instruction word (field map below)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the pass completes

Behaviour:
- Field map:
  - 49 acc, 48 CEN_pmem, 47 WEN_pmem, 46:33 A_pmem, 32 CEN1_xmem, 31:21 A1_xmem
  - 20 CEN0_xmem, 19 WEN0_xmem, 18:8 A0_xmem
  - 7 ofifo_rd, 6 ififo_wr, 5 ififo_rd, 4 l0_rd, 3 l0_wr, 2 mode, 1 execute, 0 load
- IDLE_INST has bits 48, 47, 32, 20 and 19 = 1 and all other bits 0. Port 1, ififo and acc are never used: those fields hold their IDLE_INST values at all times.
- inst is fully registered.
- Reset (reset==0 at a clk edge):
  - state=IDLE, inst=IDLE_INST, busy=0, done=0.
  - All counters and pipeline flags clear.
  - Reset mid-pass aborts the pass immediately, with no completion pulse.
- SRAM read latency is 1 cycle. The l0_wr bit is a one-cycle-delayed copy of the previous cycle's xmem read enable (~CEN0 with WEN0=1), independent of state. The delayed write may therefore land in the cycle after a read phase ends.
- States:
  - IDLE:
    - start=1 and x_len!=0 → W_RD. Latch mode, bases and x_len; clear counters.
    - x_len==0 → start is ignored.
  - W_RD:
    - Runs row cycles, i=0..row-1: CEN0=0, WEN0=1, A0=w_base+i.
    - Then → W_LOAD.
  - W_LOAD:
    - Runs row+col+1 cycles.
    - Cycles 0..row-1: l0_rd=1, load=1.
    - Cycles row..row+col-1: load=1, l0_rd=0.
    - Last cycle: bubble (all idle).
    - Then → X_RD.
  - X_RD:
    - Runs x_len cycles: CEN0=0, WEN0=1, A0=x_base+j.
    - Then → EXEC.
  - EXEC:
    - Runs x_len cycles: l0_rd=1, execute=1.
    - Then → DRAIN.
  - DRAIN:
    - Waits until wcount==x_len and no pmem write is pending.
    - Then → DONE.
  - DONE:
    - One cycle with done=1.
    - Then → IDLE.
- Output drain (active in EXEC and DRAIN):
  - When ofifo_valid=1 and rcount<x_len: ofifo_rd=1 and rcount++.
  - One cycle after each ofifo_rd: CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+wcount, then wcount++.
  - ofifo_rd may assert on consecutive cycles. Writes pipeline back-to-back.
  - When rcount==x_len, ofifo_valid is ignored. No extra reads are issued.
- Addresses wrap modulo 2^XADDR_W or 2^PADDR_W. No error is flagged.
- start while busy is ignored; its parameters are not re-latched.
- Latency (start edge to done): row + (row+col+1) + 2·x_len + drain stall + 2 cycles minimum.

Decomposition:
- Package core_ctrl_pkg holds:
  - the state enum (IDLE, W_RD, W_LOAD, X_RD, EXEC, DRAIN, DONE);
  - a localparam for the bit position of each inst field;
  - the IDLE_INST constant.
- Single module, no sub-module. One FSM plus phase counter, rcount/wcount, and the two 1-cycle delay flags (l0_wr, pmem write).

Test Plan:
1. row=col=8, w_base=0x010, x_base=0x100, x_len=4, p_base=0x0200, ofifo_valid tied 1 from EXEC:
   - A0 steps 0x010..0x017.
   - l0_wr is high exactly the 8 cycles after each read.
   - load is high 16 cycles.
   - 4 pmem writes to 0x0200..0x0203, each one cycle after ofifo_rd.
   - done one cycle after the last write.
2. Same as 1, but ofifo_valid pulsed only every 5th cycle:
   - FSM holds in DRAIN.
   - Exactly 4 ofifo_rd and 4 writes occur.
   - busy stays 1 until DONE.
3. start with x_len=0 → stays IDLE, inst==IDLE_INST, busy=0.
4. start pulsed again mid-EXEC with different p_base → ignored; writes still go to the original p_base.
5. reset=0 asserted during X_RD → next cycle inst==IDLE_INST, busy=0, no done pulse; a fresh start then completes normally.
6. x_base=0x7FE, x_len=3 → A0 sequence 0x7FE, 0x7FF, 0x000.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared constants for the core tile sequencer: FSM encodings, inst field
// positions and the idle instruction word.
package core_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t W_RD   = 3'd1;
  localparam state_t W_LOAD = 3'd2;
  localparam state_t X_RD   = 3'd3;
  localparam state_t EXEC   = 3'd4;
  localparam state_t DRAIN  = 3'd5;
  localparam state_t DONE   = 3'd6;

  localparam int INST_W     = 50;
  localparam int ACC_B      = 49;
  localparam int CEN_P_B    = 48;
  localparam int WEN_P_B    = 47;
  localparam int A_P_LSB    = 33;
  localparam int A_P_W      = 14;
  localparam int CEN1_B     = 32;
  localparam int A1_LSB     = 21;
  localparam int CEN0_B     = 20;
  localparam int WEN0_B     = 19;
  localparam int A0_LSB     = 8;
  localparam int A_X_W      = 11;
  localparam int OFIFO_RD_B = 7;
  localparam int IFIFO_WR_B = 6;
  localparam int IFIFO_RD_B = 5;
  localparam int L0_RD_B    = 4;
  localparam int L0_WR_B    = 3;
  localparam int MODE_B     = 2;
  localparam int EXECUTE_B  = 1;
  localparam int LOAD_B     = 0;

  // Both SRAM ports disabled, xmem port 0 parked in read, everything else low.
  localparam logic [INST_W-1:0] IDLE_INST =
      (INST_W'(1) << CEN_P_B) | (INST_W'(1) << WEN_P_B) | (INST_W'(1) << CEN1_B) |
      (INST_W'(1) << CEN0_B)  | (INST_W'(1) << WEN0_B);

endpackage

// File: rtl/core_ctrl.sv
// Instruction sequencer for one core tile: weight fetch, L0 load, activation
// fetch, execute and OFIFO drain into pmem, all via a registered inst word.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int XADDR_W = 11,
  parameter int PADDR_W = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [XADDR_W-1:0]  w_base,
  input  logic [XADDR_W-1:0]  x_base,
  input  logic [XADDR_W-1:0]  x_len,
  input  logic [PADDR_W-1:0]  p_base,
  input  logic                ofifo_valid,
  output logic [INST_W-1:0]   inst,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  localparam logic [XADDR_W-1:0] ONE      = XADDR_W'(1);
  localparam logic [XADDR_W-1:0] ROW_N    = XADDR_W'(row);
  localparam logic [XADDR_W-1:0] ROW_LAST = XADDR_W'(row - 1);
  localparam logic [XADDR_W-1:0] LOAD_END = XADDR_W'(row + col);

  state_t               state, state_n;
  logic [XADDR_W-1:0]   cnt, cnt_n;
  logic [XADDR_W-1:0]   rcount, wcount;
  logic [XADDR_W-1:0]   w_base_q, x_base_q, x_len_q;
  logic [PADDR_W-1:0]   p_base_q;
  logic                 mode_q;
  logic                 rd_pend;   // xmem read issued last cycle -> l0_wr now
  logic                 wr_pend;   // ofifo_rd issued last cycle -> pmem write now

  logic                 rd_en, l0_rd, load, execute, ofifo_rd;
  logic [XADDR_W-1:0]   rd_addr;
  logic [INST_W-1:0]    inst_n;

  assign dbg_state = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_en   = 1'b0;
    rd_addr = '0;
    l0_rd   = 1'b0;
    load    = 1'b0;
    execute = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start && x_len != '0) state_n = W_RD;
      end
      W_RD: begin
        rd_en   = 1'b1;
        rd_addr = w_base_q + cnt;
        if (cnt == ROW_LAST) begin
          state_n = W_LOAD;
          cnt_n   = '0;
        end else cnt_n = cnt + ONE;
      end
      W_LOAD: begin
        // row cycles reading L0, col more cycles propagating, one bubble
        l0_rd = (cnt < ROW_N);
        load  = (cnt < LOAD_END);
        if (cnt == LOAD_END) begin
          state_n = X_RD;
          cnt_n   = '0;
        end else cnt_n = cnt + ONE;
      end
      X_RD: begin
        rd_en   = 1'b1;
        rd_addr = x_base_q + cnt;
        if (cnt == x_len_q - ONE) begin
          state_n = EXEC;
          cnt_n   = '0;
        end else cnt_n = cnt + ONE;
      end
      EXEC: begin
        l0_rd   = 1'b1;
        execute = 1'b1;
        if (cnt == x_len_q - ONE) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else cnt_n = cnt + ONE;
      end
      DRAIN: begin
        if (wcount == x_len_q && !wr_pend) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ofifo_rd = (state == EXEC || state == DRAIN) && ofifo_valid && (rcount != x_len_q);
  end

  always_comb begin
    inst_n                         = IDLE_INST;
    inst_n[ACC_B]                  = 1'b0;
    inst_n[CEN1_B]                 = 1'b1;
    inst_n[A1_LSB +: A_X_W]        = '0;
    inst_n[IFIFO_WR_B]             = 1'b0;
    inst_n[IFIFO_RD_B]             = 1'b0;
    inst_n[CEN_P_B]                = ~wr_pend;
    inst_n[WEN_P_B]                = ~wr_pend;
    inst_n[A_P_LSB +: A_P_W]       = wr_pend ? (p_base_q + PADDR_W'(wcount)) : '0;
    inst_n[CEN0_B]                 = ~rd_en;
    inst_n[WEN0_B]                 = 1'b1;
    inst_n[A0_LSB +: A_X_W]        = rd_addr;
    inst_n[OFIFO_RD_B]             = ofifo_rd;
    inst_n[L0_RD_B]                = l0_rd;
    inst_n[L0_WR_B]                = rd_pend;
    inst_n[MODE_B]                 = (state != IDLE) & mode_q;
    inst_n[EXECUTE_B]              = execute;
    inst_n[LOAD_B]                 = load;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rcount   <= '0;
      wcount   <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      x_len_q  <= '0;
      p_base_q <= '0;
      mode_q   <= 1'b0;
      rd_pend  <= 1'b0;
      wr_pend  <= 1'b0;
      inst     <= IDLE_INST;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      inst    <= inst_n;
      rd_pend <= rd_en;
      wr_pend <= ofifo_rd;
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
      if (state == IDLE && state_n == W_RD) begin
        w_base_q <= w_base;
        x_base_q <= x_base;
        x_len_q  <= x_len;
        p_base_q <= p_base;
        mode_q   <= mode;
        rcount   <= '0;
        wcount   <= '0;
      end else begin
        if (ofifo_rd) rcount <= rcount + ONE;
        if (wr_pend)  wcount <= wcount + ONE;
      end
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: a per-pass expected inst/busy/done
// timeline is built from the pass rules, then compared every cycle.
module tb_core_ctrl;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int NMAX = 400;

  logic        clk = 1'b0;
  logic        reset, start, mode, ofifo_valid;
  logic [10:0] w_base, x_base, x_len;
  logic [13:0] p_base;
  logic [49:0] inst;
  logic        busy, done;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [49:0] exp_inst [NMAX];
  logic        exp_busy [NMAX];
  logic        exp_done [NMAX];
  logic        v        [NMAX];
  int          done_n;

  core_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .w_base(w_base), .x_base(x_base), .x_len(x_len), .p_base(p_base),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [49:0] idle_word();
    logic [49:0] w;
    w = '0;
    w[48] = 1'b1; w[47] = 1'b1; w[32] = 1'b1; w[20] = 1'b1; w[19] = 1'b1;
    return w;
  endfunction

  task automatic check3(input string tag, input int n, input logic [49:0] ei,
                        input logic eb, input logic ed);
    n_cmp++;
    assert (inst === ei) else begin
      n_err++;
      $error("FAIL %s inst n=%0d got=%h exp=%h", tag, n, inst, ei);
    end
    n_cmp++;
    assert (busy === eb) else begin
      n_err++;
      $error("FAIL %s busy n=%0d got=%b exp=%b", tag, n, busy, eb);
    end
    n_cmp++;
    assert (done === ed) else begin
      n_err++;
      $error("FAIL %s done n=%0d got=%b exp=%b", tag, n, done, ed);
    end
  endtask

  // Cycle n=0 is the cycle in which start is presented; the first weight
  // read appears in inst two cycles later.
  task automatic build_model(input int wb, input int xb, input int xl, input int pb,
                             input logic md);
    logic [49:0] w;
    logic        rd [NMAX];
    int xr, ex, nr, lastw;
    for (int n = 0; n < NMAX; n++) begin
      exp_inst[n] = idle_word();
      exp_busy[n] = 1'b0;
      exp_done[n] = 1'b0;
      rd[n] = 1'b0;
    end
    for (int i = 0; i < ROW; i++) begin
      w = exp_inst[2 + i]; w[20] = 1'b0; w[18:8] = 11'((wb + i) % 2048);
      exp_inst[2 + i] = w; rd[2 + i] = 1'b1;
    end
    for (int i = 0; i < ROW + COL + 1; i++) begin
      w = exp_inst[2 + ROW + i];
      if (i < ROW) begin w[4] = 1'b1; w[0] = 1'b1; end
      else if (i < ROW + COL) w[0] = 1'b1;
      exp_inst[2 + ROW + i] = w;
    end
    xr = 3 + 2 * ROW + COL;
    for (int j = 0; j < xl; j++) begin
      w = exp_inst[xr + j]; w[20] = 1'b0; w[18:8] = 11'((xb + j) % 2048);
      exp_inst[xr + j] = w; rd[xr + j] = 1'b1;
    end
    ex = xr + xl;
    for (int j = 0; j < xl; j++) begin
      w = exp_inst[ex + j]; w[4] = 1'b1; w[1] = 1'b1; exp_inst[ex + j] = w;
    end
    for (int n = 1; n < NMAX; n++)
      if (rd[n - 1]) begin w = exp_inst[n]; w[3] = 1'b1; exp_inst[n] = w; end
    nr = 0; lastw = 0;
    for (int n = ex; n < NMAX - 8 && nr < xl; n++) begin
      if (v[n - 1]) begin
        w = exp_inst[n]; w[7] = 1'b1; exp_inst[n] = w;
        w = exp_inst[n + 1]; w[48] = 1'b0; w[47] = 1'b0; w[46:33] = 14'((pb + nr) % 16384);
        exp_inst[n + 1] = w;
        nr++; lastw = n + 1;
      end
    end
    done_n = (ex + xl > lastw + 1) ? ex + xl : lastw + 1;
    if (nr < xl) done_n = NMAX - 5;
    for (int n = 2; n <= done_n + 1; n++) begin
      w = exp_inst[n]; w[2] = md; exp_inst[n] = w;
    end
    for (int n = 1; n <= done_n; n++) exp_busy[n] = 1'b1;
    exp_done[done_n] = 1'b1;
  endtask

  // vmode: 0 = valid high from just before EXEC, 1 = every 5th cycle, 2 = random
  task automatic run_pass(input string tag, input int wb, input int xb, input int xl,
                          input int pb, input logic md, input int vmode,
                          input int restart_n, input int abort_n);
    int ex, last;
    ex = 3 + 2 * ROW + COL + xl;
    for (int n = 0; n < NMAX; n++) begin
      case (vmode)
        0:       v[n] = (n >= ex - 1);
        1:       v[n] = ((n % 5) == 0);
        default: v[n] = ($urandom_range(0, 3) != 0);
      endcase
    end
    build_model(wb, xb, xl, pb, md);
    last = (abort_n >= 0) ? abort_n : done_n + 3;
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      check3(tag, n, exp_inst[n], exp_busy[n], exp_done[n]);
      if (n == 0) begin
        start = 1'b1; mode = md;
        w_base = 11'(wb); x_base = 11'(xb); x_len = 11'(xl); p_base = 14'(pb);
      end else begin
        start  = (n == restart_n);
        mode   = 1'($urandom_range(0, 1));
        w_base = 11'($urandom_range(0, 2047));
        x_base = 11'($urandom_range(0, 2047));
        x_len  = 11'($urandom_range(0, 2047));
        p_base = 14'($urandom_range(0, 16383));
      end
      ofifo_valid = v[n];
      if (n == abort_n) reset = 1'b0;
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
    if (abort_n >= 0) begin
      @(negedge clk);
      check3({tag, "_abort"}, 0, idle_word(), 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check3({tag, "_abort2"}, 1, idle_word(), 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; ofifo_valid = 1'b0;
    w_base = '0; x_base = '0; x_len = '0; p_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check3("reset", 0, idle_word(), 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check3("post_reset", 0, idle_word(), 1'b0, 1'b0);

    run_pass("basic", 'h010, 'h100, 4, 'h0200, 1'b1, 0, -1, -1);
    run_pass("slow_valid", 'h010, 'h100, 4, 'h0200, 1'b0, 1, -1, -1);

    start = 1'b1; x_len = '0; w_base = 'h010; x_base = 'h100; p_base = 'h0200; mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      check3("xlen_zero", k, idle_word(), 1'b0, 1'b0);
    end

    // restart attempt lands in the second EXEC cycle
    run_pass("restart", 'h010, 'h100, 4, 'h0200, 1'b1, 0, 3 + 2 * ROW + COL + 4 + 1, -1);
    // reset lands during the second X_RD cycle
    run_pass("abort", 'h020, 'h300, 4, 'h0100, 1'b1, 2, -1, 3 + 2 * ROW + COL + 1);
    run_pass("after_abort", 'h030, 'h040, 5, 'h0500, 1'b0, 2, -1, -1);
    run_pass("x_wrap", 'h7FC, 'h7FE, 3, 'h3FFE, 1'b1, 2, -1, -1);
    run_pass("len1", 'h000, 'h7FF, 1, 'h0000, 1'b0, 1, -1, -1);

    for (int r = 0; r < 6; r++)
      run_pass("random", int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
               int'($urandom_range(1, 12)), int'($urandom_range(0, 16383)),
               1'($urandom_range(0, 1)), 2, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
